// File: rtl/packer_pkg.sv
// Shared types for the byte-to-word packer: FSM states and the word carried through
// the output FIFO.
package packer_pkg;

    typedef enum logic {
        IDLE,
        PACK
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    localparam int unsigned WORD_W = $bits(word_t);

endpackage

// File: rtl/word_fifo2.sv
// Two-entry output FIFO. The head register drives the master port directly, so its
// contents change only on a pop or when a push lands in an empty FIFO.
module word_fifo2 #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (cnt_q != 2'd0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head_q;
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/byte_packer_32bit.sv
// Packs an 8-bit byte stream into 32-bit words with keep/last framing, forcing a packet
// boundary every PKT_WORDS words, and counts completed packets.
module byte_packer_32bit
    import packer_pkg::*;
#(
    parameter int unsigned PKT_WORDS     = 256,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        enable,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] pkt_count
);

    state_t          state_q, state_d;
    logic [1:0]      lane_q;
    logic [3:0][7:0] lanes_q, lanes_d;
    logic [15:0]     wcnt_q;
    logic [15:0]     pkt_q;
    logic            rdy_q;
    logic [1:0]      occ;
    logic            accept;
    logic            complete;
    logic            word_last;
    logic            pop;
    logic            fifo_valid;
    logic [WORD_W-1:0] fifo_dout;
    word_t           word_in;
    word_t           word_out;

    assign accept    = s_valid && s_ready;
    assign complete  = accept && (s_last || (lane_q == 2'd3));
    assign word_last = s_last || (wcnt_q == 16'(PKT_WORDS - 1));
    assign pop       = fifo_valid && m_ready;

    // Lanes above the current one are zero, so a word closed early by s_last is zero-filled.
    always_comb begin
        lanes_d         = lanes_q;
        lanes_d[lane_q] = s_data;
        word_in         = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (2'(i) > lane_q) lanes_d[i] = '0;
            word_in.keep[i] = (2'(i) <= lane_q);
            if (LITTLE_ENDIAN) word_in.data[8*i +: 8]     = lanes_d[i];
            else               word_in.data[8*(3-i) +: 8] = lanes_d[i];
        end
        word_in.last = word_last;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !(complete && word_last)) state_d = PACK;
            PACK: if (complete && word_last)              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= IDLE;
            lane_q  <= '0;
            lanes_q <= '0;
            wcnt_q  <= '0;
            pkt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (accept) begin
                if (complete) begin
                    lane_q  <= '0;
                    lanes_q <= '0;
                    wcnt_q  <= word_last ? '0 : wcnt_q + 16'd1;
                end else begin
                    lane_q  <= lane_q + 2'd1;
                    lanes_q <= lanes_d;
                end
            end
            if (pop && word_out.last) pkt_q <= pkt_q + 16'd1;
        end
    end

    word_fifo2 #(
        .W(WORD_W)
    ) u_fifo (
        .clk  (clk),
        .rstb (rstb),
        .push (complete),
        .din  (word_in),
        .pop  (pop),
        .dout (fifo_dout),
        .valid(fifo_valid),
        .count(occ)
    );

    assign word_out  = fifo_dout;
    assign s_ready   = enable && rdy_q && (occ != 2'd2);
    assign m_valid   = fifo_valid;
    assign m_data    = word_out.data;
    assign m_keep    = word_out.keep;
    assign m_last    = word_out.last;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_byte_packer_32bit.sv
// Bench for byte_packer_32bit: three instances (default, PKT_WORDS=2, big-endian with
// PKT_WORDS=3) checked by a byte-queue reference model, vector table and directed sequences.
module tb_byte_packer_32bit;

    localparam int ND = 3;

    function automatic int unsigned pw_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 3 : 256);
    endfunction

    function automatic bit le_of(input int d);
        return d != 2;
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } wrec_t;

    typedef struct {
        int          d;
        logic [31:0] bv;
        int          n;
        bit          lst;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic [15:0] ep;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        enable [ND];
    logic        s_valid[ND];
    logic [7:0]  s_data [ND];
    logic        s_last [ND];
    logic        s_ready[ND];
    logic        m_valid[ND];
    logic [31:0] m_data [ND];
    logic [3:0]  m_keep [ND];
    logic        m_last [ND];
    logic        m_ready[ND];
    logic [15:0] pkt_count[ND];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        byte_packer_32bit #(
            .PKT_WORDS    (pw_of(g)),
            .LITTLE_ENDIAN(le_of(g))
        ) u_dut (
            .clk      (clk),
            .rstb     (rstb),
            .enable   (enable[g]),
            .s_valid  (s_valid[g]),
            .s_data   (s_data[g]),
            .s_last   (s_last[g]),
            .s_ready  (s_ready[g]),
            .m_valid  (m_valid[g]),
            .m_data   (m_data[g]),
            .m_keep   (m_keep[g]),
            .m_last   (m_last[g]),
            .m_ready  (m_ready[g]),
            .pkt_count(pkt_count[g])
        );
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Reference model: pending bytes, expected FIFO contents, words in open packet.
    wrec_t       fq [ND][$];
    wrec_t       cap[ND][$];
    logic [7:0]  pb [ND][4];
    int unsigned pn [ND];
    int unsigned wip[ND];
    logic [15:0] mpkt[ND];
    bit          mrdy[ND];

    always @(negedge clk) begin
        wrec_t w;
        wrec_t cw;
        bit    exp_rdy;
        for (int d = 0; d < ND; d++) begin
            if (rstb) begin
                chk("rst_m_valid", d, 32'(m_valid[d]), 32'd0);
                chk("rst_s_ready", d, 32'(s_ready[d]), 32'd0);
                chk("rst_m_data",  d, m_data[d], 32'd0);
                chk("rst_m_keep",  d, 32'(m_keep[d]), 32'd0);
                chk("rst_m_last",  d, 32'(m_last[d]), 32'd0);
                chk("rst_pkt",     d, 32'(pkt_count[d]), 32'd0);
                fq[d].delete();
                pn[d] = 0; wip[d] = 0; mpkt[d] = '0; mrdy[d] = 0;
            end else begin
                exp_rdy = enable[d] && mrdy[d] && (fq[d].size() < 2);
                chk("s_ready", d, 32'(s_ready[d]), 32'(exp_rdy));
                chk("m_valid", d, 32'(m_valid[d]), 32'(fq[d].size() != 0));
                if (fq[d].size() != 0) begin
                    chk("m_data", d, m_data[d], fq[d][0].data);
                    chk("m_keep", d, 32'(m_keep[d]), 32'(fq[d][0].keep));
                    chk("m_last", d, 32'(m_last[d]), 32'(fq[d][0].last));
                end
                chk("pkt_count", d, 32'(pkt_count[d]), 32'(mpkt[d]));
                if (m_valid[d] && m_ready[d]) begin
                    cw.data = m_data[d]; cw.keep = m_keep[d]; cw.last = m_last[d];
                    cap[d].push_back(cw);
                end
                if (fq[d].size() != 0 && m_ready[d]) begin
                    w = fq[d].pop_front();
                    if (w.last) mpkt[d] = mpkt[d] + 16'd1;
                end
                if (s_valid[d] && exp_rdy) begin
                    pb[d][pn[d]] = s_data[d];
                    pn[d]++;
                    if (s_last[d] || pn[d] == 4) begin
                        w.data = '0;
                        for (int k = 0; k < int'(pn[d]); k++) begin
                            if (le_of(d)) w.data[8*k +: 8]     = pb[d][k];
                            else          w.data[8*(3-k) +: 8] = pb[d][k];
                        end
                        w.keep = 4'((1 << pn[d]) - 1);
                        wip[d]++;
                        w.last = s_last[d] || (wip[d] == pw_of(d));
                        if (w.last) wip[d] = 0;
                        fq[d].push_back(w);
                        pn[d] = 0;
                    end
                end
                mrdy[d] = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int d, input logic [31:0] bv, input int n, input bit lst);
        for (int k = 0; k < n; k++) begin
            bit hs;
            hs = 0;
            s_valid[d] = 1'b1;
            s_data[d]  = bv[8*k +: 8];
            s_last[d]  = lst && (k == n - 1);
            for (int c = 0; c < 50 && !hs; c++) begin
                @(negedge clk);
                hs = s_ready[d];
                tick();
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL send_timeout dut%0d byte %0d", d, k);
            end
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic offer_bytes(input int d, input logic [7:0] start, input int n,
                               input int max_cyc, output int acc);
        bit hs;
        acc = 0;
        s_valid[d] = 1'b1;
        s_last[d]  = 1'b0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            s_data[d] = start + 8'(acc);
            @(negedge clk);
            hs = s_ready[d];
            tick();
            if (hs) acc++;
        end
        s_valid[d] = 1'b0;
    endtask

    task automatic wait_cap(input int d, input int n);
        for (int c = 0; c < 40 && cap[d].size() < n; c++) tick();
        repeat (3) tick();
        chk("word_count", d, 32'(cap[d].size()), 32'(n));
    endtask

    task automatic chk_word(input int d, input int idx, input logic [31:0] ed,
                            input logic [3:0] ek, input logic el);
        if (idx < cap[d].size()) begin
            chk("word_data", d, cap[d][idx].data, ed);
            chk("word_keep", d, 32'(cap[d][idx].keep), 32'(ek));
            chk("word_last", d, 32'(cap[d][idx].last), 32'(el));
        end
    endtask

    vec_t vt[6];

    initial begin
        int acc;
        for (int d = 0; d < ND; d++) begin
            enable[d] = 1'b1; s_valid[d] = 1'b0; s_data[d] = '0;
            s_last[d] = 1'b0; m_ready[d] = 1'b1;
        end
        #2 rstb = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b0;
        tick();
        tick();

        vt[0] = '{0, 32'h04030201, 4, 1'b0, 32'h04030201, 4'hF, 1'b0, 16'd0};
        vt[1] = '{0, 32'h00CCBBAA, 3, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1, 16'd1};
        vt[2] = '{2, 32'h04030201, 4, 1'b0, 32'h01020304, 4'hF, 1'b0, 16'd0};
        vt[3] = '{0, 32'h0000005A, 1, 1'b1, 32'h0000005A, 4'h1, 1'b1, 16'd2};
        vt[4] = '{0, 32'h40302010, 4, 1'b1, 32'h40302010, 4'hF, 1'b1, 16'd3};
        vt[5] = '{2, 32'h0000BBAA, 2, 1'b1, 32'hAABB0000, 4'h3, 1'b1, 16'd1};
        for (int i = 0; i < 6; i++) begin
            cap[vt[i].d].delete();
            send_bytes(vt[i].d, vt[i].bv, vt[i].n, vt[i].lst);
            wait_cap(vt[i].d, 1);
            chk_word(vt[i].d, 0, vt[i].ed, vt[i].ek, vt[i].el);
            chk("vec_pkt", vt[i].d, 32'(pkt_count[vt[i].d]), 32'(vt[i].ep));
        end

        // PKT_WORDS=2: 12 bytes -> forced last on word 2, word 3 opens a new packet.
        cap[1].delete();
        send_bytes(1, 32'h04030201, 4, 1'b0);
        send_bytes(1, 32'h08070605, 4, 1'b0);
        send_bytes(1, 32'h0C0B0A09, 4, 1'b0);
        wait_cap(1, 3);
        chk_word(1, 0, 32'h04030201, 4'hF, 1'b0);
        chk_word(1, 1, 32'h08070605, 4'hF, 1'b1);
        chk_word(1, 2, 32'h0C0B0A09, 4'hF, 1'b0);
        chk("pkt_words_pkt", 1, 32'(pkt_count[1]), 32'd1);

        // Back-pressure: FIFO fills after 8 bytes and holds its head stable.
        cap[0].delete();
        m_ready[0] = 1'b0;
        offer_bytes(0, 8'h21, 12, 20, acc);
        chk("bp_accepted", 0, 32'(acc), 32'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_s_ready", 0, 32'(s_ready[0]), 32'd0);
            chk("bp_m_valid", 0, 32'(m_valid[0]), 32'd1);
            chk("bp_m_data",  0, m_data[0], 32'h24232221);
            tick();
        end
        m_ready[0] = 1'b1;
        send_bytes(0, 32'h2C2B2A29, 4, 1'b0);
        wait_cap(0, 3);
        chk_word(0, 0, 32'h24232221, 4'hF, 1'b0);
        chk_word(0, 1, 32'h28272625, 4'hF, 1'b0);
        chk_word(0, 2, 32'h2C2B2A29, 4'hF, 1'b0);

        // Reset mid-word discards the partial bytes.
        send_bytes(0, 32'h00006655, 2, 1'b0);
        rstb = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", 0, 32'(m_valid[0]), 32'd0);
        chk("mid_rst_m_data",  0, m_data[0], 32'd0);
        chk("mid_rst_m_keep",  0, 32'(m_keep[0]), 32'd0);
        chk("mid_rst_m_last",  0, 32'(m_last[0]), 32'd0);
        chk("mid_rst_s_ready", 0, 32'(s_ready[0]), 32'd0);
        chk("mid_rst_pkt",     0, 32'(pkt_count[0]), 32'd0);
        tick();
        rstb = 1'b0;
        cap[0].delete();
        send_bytes(0, 32'h44332211, 4, 1'b0);
        wait_cap(0, 1);
        chk_word(0, 0, 32'h44332211, 4'hF, 1'b0);

        // Enable dropped mid-word keeps partial lanes.
        cap[0].delete();
        send_bytes(0, 32'h00007271, 2, 1'b0);
        enable[0] = 1'b0;
        s_valid[0] = 1'b1;
        s_data[0] = 8'h99;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("en_low_ready", 0, 32'(s_ready[0]), 32'd0);
            tick();
        end
        s_valid[0] = 1'b0;
        enable[0] = 1'b1;
        send_bytes(0, 32'h00007473, 2, 1'b0);
        wait_cap(0, 1);
        chk_word(0, 0, 32'h74737271, 4'hF, 1'b0);

        // Random traffic on all instances against the reference model.
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < ND; d++) begin
                s_valid[d] = ($urandom_range(0, 3) != 0);
                s_data[d]  = 8'($urandom);
                s_last[d]  = ($urandom_range(0, 7) == 0);
                enable[d]  = ($urandom_range(0, 9) != 0);
                m_ready[d] = ($urandom_range(0, 3) != 0);
            end
            if (i == 1500) rstb = 1'b1;
            if (i == 1503) rstb = 1'b0;
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            s_valid[d] = 1'b0; s_last[d] = 1'b0; enable[d] = 1'b1; m_ready[d] = 1'b1;
        end
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
